// File: rtl/vc_allocator_rr.sv
// Round-robin virtual-channel allocator for one NoC router input port.
// Define VC_ALLOC_STATS_EN to add saturating allocation/drop counters.
module vc_allocator_rr #(
    parameter int FLIT_W = 32,
    parameter int ADDR_W = 4,
    parameter int NUM_VC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FLIT_W-1:0] flit_in,
    input  logic              flit_in_valid,
    output logic              flit_in_ready,
    input  logic [NUM_VC-1:0] vc_ready,
    input  logic              err_clr,
    output logic [FLIT_W-1:0] flit_out,
    output logic [NUM_VC-1:0] flit_out_vld,
    output logic [NUM_VC-1:0] vc_busy,
    output logic              error,
    output logic [1:0]        err_code
`ifdef VC_ALLOC_STATS_EN
    ,
    output logic [15:0]       alloc_cnt,
    output logic [15:0]       drop_cnt
`endif
);

    localparam int PTR_W = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;

    typedef enum logic {VC_IDLE = 1'b0, VC_ACTIVE = 1'b1} vc_state_e;
    typedef enum logic [1:0] {
        FT_BODY = 2'b00, FT_TAIL = 2'b01, FT_HEAD = 2'b10, FT_HEAD_TAIL = 2'b11
    } flit_type_e;
    typedef enum logic [1:0] {
        ERR_NONE = 2'b00, ERR_ORPHAN = 2'b01, ERR_DUP = 2'b10, ERR_BAD_TYPE = 2'b11
    } err_code_e;

    vc_state_e         vc_state_q [NUM_VC];
    vc_state_e         vc_state_d [NUM_VC];
    logic [ADDR_W-1:0] owner_q    [NUM_VC];
    logic [ADDR_W-1:0] owner_d    [NUM_VC];
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [FLIT_W-1:0] flit_out_q, flit_out_d;
    logic [NUM_VC-1:0] flit_out_vld_q, flit_out_vld_d;
    logic              error_q, error_d;
    logic [1:0]        err_code_q, err_code_d;

    logic [1:0]        flit_type;
    logic [ADDR_W-1:0] src;
    logic              has_match;
    logic [PTR_W-1:0]  match_idx;
    logic              cand_found;
    logic [PTR_W-1:0]  cand_idx;
    logic [PTR_W-1:0]  cand_next;
    logic              fwd;
    logic [PTR_W-1:0]  fwd_idx;
    logic              drop;
    err_code_e         cause;

    assign flit_type = flit_in[FLIT_W-1 -: 2];
    assign src       = flit_in[FLIT_W-3 -: ADDR_W];

    // Owners of ACTIVE VCs are unique, so the first match is the only match.
    always_comb begin : match_comb
        has_match = 1'b0;
        match_idx = '0;
        for (int unsigned i = 0; i < NUM_VC; i++) begin
            if (!has_match && vc_state_q[i] == VC_ACTIVE && owner_q[i] == src) begin
                has_match = 1'b1;
                match_idx = PTR_W'(i);
            end
        end
    end

    always_comb begin : cand_comb
        int unsigned idx;
        cand_found = 1'b0;
        cand_idx   = '0;
        for (int unsigned k = 0; k < NUM_VC; k++) begin
            idx = (32'(rr_ptr_q) + k) % NUM_VC;
            if (!cand_found && vc_state_q[idx[PTR_W-1:0]] == VC_IDLE
                && vc_ready[idx[PTR_W-1:0]]) begin
                cand_found = 1'b1;
                cand_idx   = idx[PTR_W-1:0];
            end
        end
        cand_next = (cand_idx == PTR_W'(NUM_VC - 1)) ? '0 : cand_idx + 1'b1;
    end

    always_comb begin : alloc_comb
        flit_in_ready = 1'b0;
        fwd           = 1'b0;
        fwd_idx       = '0;
        drop          = 1'b0;
        cause         = ERR_NONE;
        rr_ptr_d      = rr_ptr_q;
        for (int unsigned i = 0; i < NUM_VC; i++) begin
            vc_state_d[i] = vc_state_q[i];
            owner_d[i]    = owner_q[i];
        end

        case (flit_type)
            FT_HEAD, FT_HEAD_TAIL: begin
                if (has_match) begin
                    flit_in_ready = 1'b1;
                    drop          = flit_in_valid;
                    cause         = ERR_DUP;
                end else if (cand_found) begin
                    flit_in_ready = 1'b1;
                    if (flit_in_valid) begin
                        fwd      = 1'b1;
                        fwd_idx  = cand_idx;
                        rr_ptr_d = cand_next;
                        if (flit_type == FT_HEAD) begin
                            vc_state_d[cand_idx] = VC_ACTIVE;
                            owner_d[cand_idx]    = src;
                        end
                    end
                end
            end
            FT_BODY, FT_TAIL: begin
                if (has_match) begin
                    flit_in_ready = vc_ready[match_idx];
                    if (flit_in_valid && vc_ready[match_idx]) begin
                        fwd     = 1'b1;
                        fwd_idx = match_idx;
                        if (flit_type == FT_TAIL) begin
                            vc_state_d[match_idx] = VC_IDLE;
                        end
                    end
                end else begin
                    flit_in_ready = 1'b1;
                    drop          = flit_in_valid;
                    cause         = ERR_ORPHAN;
                end
            end
            default: begin
                flit_in_ready = 1'b1;
                drop          = flit_in_valid;
                cause         = ERR_BAD_TYPE;
            end
        endcase
    end

    always_comb begin : out_comb
        flit_out_d     = fwd ? flit_in : flit_out_q;
        flit_out_vld_d = '0;
        if (fwd) begin
            flit_out_vld_d[fwd_idx] = 1'b1;
        end
        // A new error beats a simultaneous clear and records its own cause.
        error_d    = error_q;
        err_code_d = err_code_q;
        if (drop) begin
            error_d = 1'b1;
            if (!error_q || err_clr) begin
                err_code_d = cause;
            end
        end else if (err_clr) begin
            error_d    = 1'b0;
            err_code_d = ERR_NONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_VC; i++) begin
                vc_state_q[i] <= VC_IDLE;
                owner_q[i]    <= '0;
            end
            rr_ptr_q       <= '0;
            flit_out_q     <= '0;
            flit_out_vld_q <= '0;
            error_q        <= 1'b0;
            err_code_q     <= ERR_NONE;
        end else begin
            for (int unsigned i = 0; i < NUM_VC; i++) begin
                vc_state_q[i] <= vc_state_d[i];
                owner_q[i]    <= owner_d[i];
            end
            rr_ptr_q       <= rr_ptr_d;
            flit_out_q     <= flit_out_d;
            flit_out_vld_q <= flit_out_vld_d;
            error_q        <= error_d;
            err_code_q     <= err_code_d;
        end
    end

    always_comb begin : busy_comb
        vc_busy = '0;
        for (int unsigned i = 0; i < NUM_VC; i++) begin
            vc_busy[i] = (vc_state_q[i] == VC_ACTIVE);
        end
    end

    assign flit_out     = flit_out_q;
    assign flit_out_vld = flit_out_vld_q;
    assign error        = error_q;
    assign err_code     = err_code_q;

`ifdef VC_ALLOC_STATS_EN
    logic [15:0] alloc_cnt_q, alloc_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin : stats_comb
        alloc_cnt_d = alloc_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        if (fwd && flit_type[1] && alloc_cnt_q != '1) begin
            alloc_cnt_d = alloc_cnt_q + 16'd1;
        end
        if (drop && drop_cnt_q != '1) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alloc_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            alloc_cnt_q <= alloc_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign alloc_cnt = alloc_cnt_q;
    assign drop_cnt  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_vc_allocator_rr.sv
// Self-checking bench for vc_allocator_rr: directed scenarios plus random traffic
// compared against a packet-level reference model.
module tb_vc_allocator_rr;

    localparam int FLIT_W = 32;
    localparam int ADDR_W = 4;
    localparam int NUM_VC = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [FLIT_W-1:0] flit_in = '0;
    logic              flit_in_valid = 1'b0;
    logic              flit_in_ready;
    logic [NUM_VC-1:0] vc_ready = '0;
    logic              err_clr = 1'b0;
    logic [FLIT_W-1:0] flit_out;
    logic [NUM_VC-1:0] flit_out_vld;
    logic [NUM_VC-1:0] vc_busy;
    logic              error;
    logic [1:0]        err_code;
`ifdef VC_ALLOC_STATS_EN
    logic [15:0]       alloc_cnt;
    logic [15:0]       drop_cnt;
`endif

    vc_allocator_rr #(.FLIT_W(FLIT_W), .ADDR_W(ADDR_W), .NUM_VC(NUM_VC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flit_in      (flit_in),
        .flit_in_valid(flit_in_valid),
        .flit_in_ready(flit_in_ready),
        .vc_ready     (vc_ready),
        .err_clr      (err_clr),
        .flit_out     (flit_out),
        .flit_out_vld (flit_out_vld),
        .vc_busy      (vc_busy),
        .error        (error),
        .err_code     (err_code)
`ifdef VC_ALLOC_STATS_EN
        ,
        .alloc_cnt    (alloc_cnt),
        .drop_cnt     (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: packet bookkeeping per VC
    bit                m_busy  [NUM_VC];
    int                m_owner [NUM_VC];
    int                m_rr;
    bit                m_err;
    logic [1:0]        m_code;
    logic [FLIT_W-1:0] m_fout;
    logic [NUM_VC-1:0] m_vld;
    int                m_alloc;
    int                m_drop;

    task automatic model_reset();
        for (int i = 0; i < NUM_VC; i++) begin
            m_busy[i]  = 1'b0;
            m_owner[i] = 0;
        end
        m_rr = 0; m_err = 1'b0; m_code = 2'b00;
        m_fout = '0; m_vld = '0; m_alloc = 0; m_drop = 0;
    endtask

    function automatic logic [NUM_VC-1:0] model_busy();
        logic [NUM_VC-1:0] b;
        b = '0;
        for (int i = 0; i < NUM_VC; i++) b[i] = m_busy[i];
        return b;
    endfunction

    task automatic check_outputs(input string ctx);
        check({ctx, ".vld"},      flit_out_vld, m_vld);
        check({ctx, ".flit_out"}, flit_out,     m_fout);
        check({ctx, ".busy"},     vc_busy,      model_busy());
        check({ctx, ".error"},    error,        m_err);
        check({ctx, ".err_code"}, err_code,     m_code);
`ifdef VC_ALLOC_STATS_EN
        check({ctx, ".alloc_cnt"}, alloc_cnt, 16'(m_alloc));
        check({ctx, ".drop_cnt"},  drop_cnt,  16'(m_drop));
`endif
    endtask

    task automatic cycle(input logic [FLIT_W-1:0] f, input bit v,
                         input logic [NUM_VC-1:0] vr, input bit clr);
        int t, s, match, cand, fwd, idx;
        bit rdy, drop;
        logic [1:0] cause;
        @(negedge clk);
        flit_in = f; flit_in_valid = v; vc_ready = vr; err_clr = clr;
        #1;
        t = int'(f[FLIT_W-1 -: 2]);
        s = int'(f[FLIT_W-3 -: ADDR_W]);
        match = -1;
        for (int i = 0; i < NUM_VC; i++)
            if (m_busy[i] && m_owner[i] == s) match = i;
        rdy = 1'b0; fwd = -1; drop = 1'b0; cause = 2'b00;
        if (t >= 2) begin
            if (match >= 0) begin
                rdy = 1'b1; drop = v; cause = 2'b10;
            end else begin
                cand = -1;
                for (int k = 0; k < NUM_VC; k++) begin
                    idx = (m_rr + k) % NUM_VC;
                    if (cand < 0 && !m_busy[idx] && vr[idx]) cand = idx;
                end
                if (cand >= 0) begin
                    rdy = 1'b1;
                    if (v) fwd = cand;
                end
            end
        end else begin
            if (match >= 0) begin
                rdy = vr[match];
                if (v && rdy) fwd = match;
            end else begin
                rdy = 1'b1; drop = v; cause = 2'b01;
            end
        end
        check("ready", flit_in_ready, rdy);
        @(posedge clk);
        m_vld = '0;
        if (fwd >= 0) begin
            m_fout = f;
            m_vld[fwd] = 1'b1;
            if (t >= 2) begin
                if (m_alloc < 65535) m_alloc++;
                m_rr = (fwd + 1) % NUM_VC;
                if (t == 2) begin
                    m_busy[fwd]  = 1'b1;
                    m_owner[fwd] = s;
                end
            end else if (t == 1) begin
                m_busy[fwd] = 1'b0;
            end
        end
        if (drop) begin
            if (m_drop < 65535) m_drop++;
            if (!m_err || clr) m_code = cause;
            m_err = 1'b1;
        end else if (clr) begin
            m_err = 1'b0; m_code = 2'b00;
        end
        #1;
        check_outputs("cyc");
    endtask

    // Reset lands mid-cycle to exercise the asynchronous path.
    task automatic async_reset();
        @(negedge clk);
        flit_in_valid = 1'b0; err_clr = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("rst.vld",      flit_out_vld, '0);
        check("rst.flit_out", flit_out,     '0);
        check("rst.busy",     vc_busy,      '0);
        check("rst.error",    error,        1'b0);
        check("rst.err_code", err_code,     2'b00);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    localparam logic [FLIT_W-1:0] H3  = 32'h8C00_0001;
    localparam logic [FLIT_W-1:0] H5  = 32'h9400_0001;
    localparam logic [FLIT_W-1:0] H7  = 32'h9C00_0001;
    localparam logic [FLIT_W-1:0] T3  = 32'h4C00_0003;
    localparam logic [FLIT_W-1:0] B3  = 32'h0C00_0002;
    localparam logic [FLIT_W-1:0] B6  = 32'h1800_0000;
    localparam logic [FLIT_W-1:0] HT7 = 32'hDC00_0001;

    initial begin
        logic [FLIT_W-1:0] f;
        logic [1:0] ty;
        logic [ADDR_W-1:0] sa;

        model_reset();
        #12;
        check_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Two headers fill both VCs in round-robin order
        cycle(H3, 1, 2'b11, 0);
        check("tp.h3_vld", flit_out_vld, 2'b01);
        cycle(H5, 1, 2'b11, 0);
        check("tp.h5_vld", flit_out_vld, 2'b10);
        check("tp.h5_busy", vc_busy, 2'b11);
        // Stall while no VC is free, then the tail frees VC0
        cycle(H7, 1, 2'b11, 0);
        cycle(T3, 1, 2'b11, 0);
        check("tp.t3_vld", flit_out_vld, 2'b01);
        cycle(H7, 1, 2'b11, 0);
        check("tp.h7_vc0", flit_out_vld, 2'b01);
        cycle(H3, 1, 2'b11, 0);   // duplicate-free: src 3 released, but no VC free -> stall

        // Body backpressure
        async_reset();
        cycle(H3, 1, 2'b11, 0);
        cycle(B3, 1, 2'b10, 0);
        check("tp.b3_stall_vld", flit_out_vld, 2'b00);
        cycle(B3, 1, 2'b11, 0);
        check("tp.b3_vld", flit_out_vld, 2'b01);
        // Duplicate header, orphan body, clear
        cycle(H3, 1, 2'b11, 0);
        check("tp.dup_code", err_code, 2'b10);
        cycle(B6, 1, 2'b11, 0);
        check("tp.first_code_kept", err_code, 2'b10);
        cycle(B6, 1, 2'b11, 1);
        check("tp.clr_err_wins", err_code, 2'b01);
        cycle(B6, 0, 2'b11, 1);
        check("tp.clr_error", error, 1'b0);

        // Single-flit packets and mid-packet reset
        async_reset();
        cycle(HT7, 1, 2'b11, 0);
        check("tp.ht_vld0", flit_out_vld, 2'b01);
        cycle(HT7, 1, 2'b11, 0);
        check("tp.ht_vld1", flit_out_vld, 2'b10);
        check("tp.ht_busy", vc_busy, 2'b00);
        cycle(H3, 1, 2'b11, 0);
        async_reset();
        cycle(B3, 1, 2'b11, 0);
        check("tp.post_rst_orphan", err_code, 2'b01);

        // Random traffic over a small address space to provoke matches
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                async_reset();
            end else begin
                ty = 2'($urandom_range(0, 3));
                sa = ADDR_W'($urandom_range(0, 5));
                f  = {ty, sa, 26'($urandom)};
                cycle(f, $urandom_range(0, 9) < 8, NUM_VC'($urandom),
                      $urandom_range(0, 9) == 0);
            end
        end

`ifdef VC_ALLOC_STATS_EN
        for (int n = 0; n < 65540; n++) begin
            cycle(B6, 1, 2'b11, 0);
        end
        check("stats.drop_sat", drop_cnt, 16'hFFFF);
        async_reset();
        check("stats.drop_rst", drop_cnt, 16'h0000);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
